// File: rtl/xfer_pkg.sv
// xfer_pkg
// Shared types and constants for the byte-serial transmit stage.
//   XFER_LEN_W   : width of the transfer length and the sent-byte counter
//   XFER_BYTE_W  : width of one bus byte
//   xfer_state_e : transmit FSM states
//   transfer_s   : record of one transfer as seen on the bus (last data
//                  byte, address, number of data bytes)
package xfer_pkg;

    localparam int XFER_LEN_W  = 5;
    localparam int XFER_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        STOP
    } xfer_state_e;

    typedef struct packed {
        logic [XFER_BYTE_W-1:0] data;
        logic [XFER_BYTE_W-1:0] addr;
        int                     count;
    } transfer_s;

endpackage

// File: rtl/xfer_byte_fifo.sv
// xfer_byte_fifo
// Payload byte FIFO with an occupancy counter.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write wdata (ignored when full)
//   wdata      : byte to write
//   pop        : drop the head byte (ignored when empty)
//   full       : DEPTH bytes held
//   empty      : no bytes held
//   rdata      : head byte, valid whenever empty is low
module xfer_byte_fifo
    import xfer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [XFER_BYTE_W-1:0] wdata,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [XFER_BYTE_W-1:0] rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [XFER_BYTE_W-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   do_push;
    logic                   do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap explicitly at DEPTH; a simultaneous push and pop
    // leaves the occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Storage needs no reset: entries are only read once the counter
    // says they were written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/xfer_bus_driver.sv
// xfer_bus_driver
// Transmit stage for the byte-serial bus: sends an address byte, then
// req_len payload bytes taken from an internal FIFO, then holds stop_cond
// for STOP_CYCLES cycles and pulses done.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/ready       : transfer request handshake
//   req_addr, req_len     : address byte and payload length (0..31)
//   byte_valid/ready/data : payload byte input into the FIFO
//   bus_data, bus_valid   : registered bus byte and its qualifier
//   bus_is_addr           : bus_data carries the address
//   stop_cond             : stop condition for the downstream sampler
//   busy                  : FSM is not idle
//   done, done_count      : end-of-transfer pulse and bytes sent
module xfer_bus_driver
    import xfer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int STOP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [XFER_BYTE_W-1:0] req_addr,
    input  logic [XFER_LEN_W-1:0]  req_len,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    input  logic [XFER_BYTE_W-1:0] byte_data,
    output logic [XFER_BYTE_W-1:0] bus_data,
    output logic                   bus_valid,
    output logic                   bus_is_addr,
    output logic                   stop_cond,
    output logic                   busy,
    output logic                   done,
    output logic [XFER_LEN_W-1:0]  done_count
);

    localparam int SCW = $clog2(STOP_CYCLES + 1);
    localparam logic [SCW-1:0]        STOP_LOAD = SCW'(STOP_CYCLES);
    localparam logic [SCW-1:0]        STOP_ONE  = SCW'(1);
    localparam logic [XFER_LEN_W-1:0] LEN_ONE   = XFER_LEN_W'(1);

    xfer_state_e            state;
    xfer_state_e            next_state;
    logic [XFER_LEN_W-1:0]  len_q;
    logic [XFER_LEN_W-1:0]  sent;
    logic [XFER_LEN_W-1:0]  sent_next;
    logic [SCW-1:0]         stop_cnt;
    logic [SCW-1:0]         stop_cnt_next;

    logic                   accept;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [XFER_BYTE_W-1:0] fifo_rdata;

    logic [XFER_BYTE_W-1:0] bus_data_d;
    logic                   bus_valid_d;
    logic                   bus_is_addr_d;
    logic                   stop_cond_d;
    logic                   busy_d;
    logic                   req_ready_d;
    logic                   done_d;
    logic [XFER_LEN_W-1:0]  done_count_d;

    xfer_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (byte_valid),
        .wdata (byte_data),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (fifo_rdata)
    );

    assign byte_ready = !fifo_full;
    assign accept     = (state == IDLE) && req_valid;

    // State register plus the transfer bookkeeping that moves with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            sent     <= '0;
            stop_cnt <= '0;
        end else begin
            state    <= next_state;
            sent     <= sent_next;
            stop_cnt <= stop_cnt_next;
            if (accept) begin
                len_q <= req_len;
            end
        end
    end

    // Next-state logic. The state names the bus cycle being shown, so a
    // DATA cycle whose byte count has reached len is the last data cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = ADDR;
            ADDR:    next_state = (len_q == '0) ? STOP : DATA;
            DATA:    if (sent == len_q) next_state = STOP;
            STOP:    if (stop_cnt == STOP_ONE) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: computes what the registered outputs show in the next
    // cycle. A byte is popped at the edge entering a DATA cycle, so the bus
    // register and the FIFO move together; an empty FIFO gives a stall.
    always_comb begin
        fifo_pop      = (next_state == DATA) && !fifo_empty;
        sent_next     = sent;
        stop_cnt_next = stop_cnt;
        bus_data_d    = bus_data;
        if (accept) begin
            sent_next  = '0;
            bus_data_d = req_addr;
        end else if (fifo_pop) begin
            sent_next  = sent + LEN_ONE;
            bus_data_d = fifo_rdata;
        end
        if (next_state == STOP) begin
            stop_cnt_next = (state == STOP) ? stop_cnt - STOP_ONE : STOP_LOAD;
        end
        bus_valid_d   = accept || fifo_pop;
        bus_is_addr_d = accept;
        stop_cond_d   = (next_state == STOP);
        busy_d        = (next_state != IDLE);
        req_ready_d   = (next_state == IDLE);
        done_d        = (next_state == STOP) && (stop_cnt_next == STOP_ONE);
        done_count_d  = done_d ? sent_next : done_count;
    end

    // Output registers; reset leaves only the ready flag high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_data    <= '0;
            bus_valid   <= 1'b0;
            bus_is_addr <= 1'b0;
            stop_cond   <= 1'b0;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
            done        <= 1'b0;
            done_count  <= '0;
        end else begin
            bus_data    <= bus_data_d;
            bus_valid   <= bus_valid_d;
            bus_is_addr <= bus_is_addr_d;
            stop_cond   <= stop_cond_d;
            busy        <= busy_d;
            req_ready   <= req_ready_d;
            done        <= done_d;
            done_count  <= done_count_d;
        end
    end

endmodule

// File: tb/tb_xfer_bus_driver.sv
// tb_xfer_bus_driver
// Self-checking bench for xfer_bus_driver: a vector table of simple
// transfers plus hand-written stall, full-FIFO, reset and back-to-back
// sequences. A negedge monitor compares every bus beat and done pulse
// against a scoreboard filled when stimulus is accepted.
module tb_xfer_bus_driver;
    import xfer_pkg::*;

    localparam int DEPTH       = 4;
    localparam int STOP_CYCLES = 2;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [4:0] req_len;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic [7:0] bus_data;
    logic       bus_valid;
    logic       bus_is_addr;
    logic       stop_cond;
    logic       busy;
    logic       done;
    logic [4:0] done_count;

    typedef struct packed {
        logic       is_addr;
        logic [7:0] val;
    } exp_beat_t;

    typedef struct packed {
        logic [7:0]      addr;
        logic [4:0]      len;
        int              npre;
        logic [3:0][7:0] bytes;
        int              exp_busy;
        logic [7:0]      exp_last;
    } vec_t;

    exp_beat_t  exp_kind[$];
    logic [7:0] model_bytes[$];
    int         exp_done[$];
    exp_beat_t  mon_beat;
    transfer_s  cur_xfer;
    transfer_s  last_xfer;
    vec_t       vecs[5];
    int         checks      = 0;
    int         failures    = 0;
    int         done_pulses = 0;

    xfer_bus_driver #(
        .DEPTH       (DEPTH),
        .STOP_CYCLES (STOP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_data   (byte_data),
        .bus_data    (bus_data),
        .bus_valid   (bus_valid),
        .bus_is_addr (bus_is_addr),
        .stop_cond   (stop_cond),
        .busy        (busy),
        .done        (done),
        .done_count  (done_count)
    );

    // Free-running clock, rising edge every 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [7:0] a, input logic [4:0] l, input int n,
                                   input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2, input logic [7:0] b3,
                                   input int eb, input logic [7:0] el);
        vec_t v;
        v.addr     = a;
        v.len      = l;
        v.npre     = n;
        v.bytes    = {b3, b2, b1, b0};
        v.exp_busy = eb;
        v.exp_last = el;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs from the posedge+1 phase and returns at
    // the next posedge+1. Handshakes are decided from the ready flags,
    // which are stable until the edge, and recorded in the scoreboard.
    task automatic applyStimulus(input logic rv, input logic [7:0] ra, input logic [4:0] rl,
                                 input logic bv, input logic [7:0] bd);
        exp_beat_t b;
        req_valid  = rv;
        req_addr   = ra;
        req_len    = rl;
        byte_valid = bv;
        byte_data  = bd;
        if (rv && req_ready) begin
            b.is_addr = 1'b1;
            b.val     = ra;
            exp_kind.push_back(b);
            for (int k = 0; k < int'(rl); k++) begin
                b.is_addr = 1'b0;
                b.val     = 8'h00;
                exp_kind.push_back(b);
            end
            exp_done.push_back(int'(rl));
        end
        if (bv && byte_ready) begin
            model_bytes.push_back(bd);
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Counts busy and stop cycles until done, bounded by max_cycles.
    task automatic waitDone(input int max_cycles, output int busy_c, output int stop_c);
        bit seen;
        seen   = 1'b0;
        busy_c = 0;
        stop_c = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_c++;
            if (stop_cond) stop_c++;
            if (done) seen = 1'b1;
        end
        checkOutput("done_seen", int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    // Proves the FIFO holds nothing: a len=1 request must stall until a
    // fresh byte arrives, and that byte is the one sent.
    task automatic verifyEmpty();
        int bc;
        int sc;
        applyStimulus(1'b1, 8'hE7, 5'd1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00);
            checkOutput("empty_stall", int'(bus_valid), 0);
        end
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1, 8'h3D);
        waitDone(20, bc, sc);
    endtask

    // Scoreboard monitor: every valid beat must match the next expected
    // beat, and every done must match the next expected count.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stop_cond) checkOutput("stop_no_valid", int'(bus_valid), 0);
            if (bus_valid) begin
                checkOutput("beat_expected", int'(exp_kind.size() > 0), 1);
                if (exp_kind.size() > 0) begin
                    mon_beat = exp_kind.pop_front();
                    checkOutput("beat_is_addr", int'(bus_is_addr), int'(mon_beat.is_addr));
                    if (mon_beat.is_addr) begin
                        checkOutput("addr_beat", int'(bus_data), int'(mon_beat.val));
                        cur_xfer.addr  = bus_data;
                        cur_xfer.data  = 8'h00;
                        cur_xfer.count = 0;
                    end else begin
                        checkOutput("data_expected", int'(model_bytes.size() > 0), 1);
                        if (model_bytes.size() > 0) begin
                            checkOutput("data_beat", int'(bus_data), int'(model_bytes.pop_front()));
                        end
                        cur_xfer.data  = bus_data;
                        cur_xfer.count = cur_xfer.count + 1;
                    end
                end
            end
            if (done) begin
                done_pulses++;
                checkOutput("done_expected", int'(exp_done.size() > 0), 1);
                if (exp_done.size() > 0) begin
                    checkOutput("done_count", int'(done_count), exp_done[0]);
                    checkOutput("sampler_count", cur_xfer.count, exp_done.pop_front());
                end
                checkOutput("beats_left", exp_kind.size(), 0);
                last_xfer = cur_xfer;
            end
        end
    end

    initial begin
        int bc;
        int sc;
        int beats;
        int gap;
        int base;
        int done_cyc;
        int acc_cyc;
        bit seen;
        logic [7:0] prev_data;

        vecs[0] = mkVec(8'h10, 5'd2, 2, 8'hAA, 8'hBB, 8'h00, 8'h00, 5, 8'hBB);
        vecs[1] = mkVec(8'h3C, 5'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'h00);
        vecs[2] = mkVec(8'h55, 5'd1, 1, 8'h5E, 8'h00, 8'h00, 8'h00, 4, 8'h5E);
        vecs[3] = mkVec(8'hA0, 5'd4, 4, 8'h01, 8'h02, 8'h03, 8'h04, 7, 8'h04);
        vecs[4] = mkVec(8'hFF, 5'd3, 3, 8'h80, 8'h7F, 8'h00, 8'h00, 6, 8'h00);

        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 8'h00;
        req_len    = 5'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        cur_xfer   = '0;
        last_xfer  = '0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_bus_data", int'(bus_data), 0);
        checkOutput("rst_flags", int'({bus_valid, bus_is_addr, stop_cond, busy, done}), 0);
        checkOutput("rst_done_count", int'(done_count), 0);
        checkOutput("rst_req_ready", int'(req_ready), 1);
        checkOutput("rst_byte_ready", int'(byte_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven transfers with no stalls.
        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < vecs[v].npre; j++) begin
                applyStimulus(1'b0, 8'h00, 5'd0, 1'b1, vecs[v].bytes[j]);
            end
            checkOutput("req_ready_idle", int'(req_ready), 1);
            applyStimulus(1'b1, vecs[v].addr, vecs[v].len, 1'b0, 8'h00);
            waitDone(100, bc, sc);
            checkOutput("busy_cycles", bc, vecs[v].exp_busy);
            checkOutput("stop_cycles", sc, STOP_CYCLES);
            checkOutput("sampler_addr", int'(last_xfer.addr), int'(vecs[v].addr));
            checkOutput("sampler_total", last_xfer.count, int'(vecs[v].len));
            if (vecs[v].len != 5'd0) begin
                checkOutput("sampler_data", int'(last_xfer.data), int'(vecs[v].exp_last));
            end
            checkOutput("idle_after_done", int'({busy, req_ready}), 1);
        end

        // Stalls: len=3 from an empty FIFO, one byte pushed every 3 cycles.
        applyStimulus(1'b1, 8'h5A, 5'd3, 1'b0, 8'h00);
        prev_data = bus_data;
        beats     = 0;
        gap       = -1;
        seen      = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            applyStimulus(1'b0, 8'h00, 5'd0, (i % 3 == 0) && (i < 9), 8'(8'h60 + i));
            if (done) seen = 1'b1;
            if (!stop_cond && busy) begin
                if (bus_valid) begin
                    beats++;
                    if (gap >= 0) checkOutput("stall_gap", gap, 2);
                    gap = 0;
                end else begin
                    checkOutput("stall_hold", int'(bus_data), int'(prev_data));
                    if (gap >= 0) gap++;
                end
            end
            prev_data = bus_data;
        end
        checkOutput("stall_done", int'(seen), 1);
        checkOutput("stall_beats", beats, 3);
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00);

        // Full FIFO: an extra push is refused, surplus carries over.
        for (int j = 0; j < DEPTH; j++) begin
            applyStimulus(1'b0, 8'h00, 5'd0, 1'b1, 8'(8'hC1 + j));
        end
        checkOutput("byte_ready_full", int'(byte_ready), 0);
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1, 8'hC5);
        checkOutput("byte_ready_still_full", int'(byte_ready), 0);
        applyStimulus(1'b1, 8'h40, 5'd2, 1'b0, 8'h00);
        waitDone(50, bc, sc);
        checkOutput("byte_ready_after", int'(byte_ready), 1);
        applyStimulus(1'b1, 8'h41, 5'd2, 1'b0, 8'h00);
        waitDone(50, bc, sc);
        checkOutput("second_half_busy", bc, 5);
        verifyEmpty();

        // Reset in the middle of a len=5 transfer with bytes still queued.
        for (int j = 0; j < DEPTH; j++) begin
            applyStimulus(1'b0, 8'h00, 5'd0, 1'b1, 8'(8'h11 * (j + 1)));
        end
        applyStimulus(1'b1, 8'h77, 5'd5, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00);
        checkOutput("pre_reset_data", int'({bus_valid, bus_data}), 'h111);
        rst_n = 1'b0;
        exp_kind.delete();
        model_bytes.delete();
        exp_done.delete();
        cur_xfer = '0;
        #1;
        checkOutput("midrst_outputs", int'({bus_data, bus_valid, bus_is_addr, stop_cond, busy, done, done_count}), 0);
        checkOutput("midrst_ready", int'({req_ready, byte_ready}), 3);
        base = done_pulses;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("post_rst_req_ready", int'(req_ready), 1);
        repeat (5) applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00);
        checkOutput("no_done_after_rst", done_pulses, base);
        verifyEmpty();

        // Back-to-back len=1 requests; req_valid held high throughout.
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1, 8'h9A);
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1, 8'h9B);
        base = done_pulses;
        applyStimulus(1'b1, 8'h21, 5'd1, 1'b0, 8'h00);
        done_cyc = -1;
        acc_cyc  = -1;
        for (int i = 0; i < 20; i++) begin
            if (done) done_cyc = i;
            if (req_ready) begin
                acc_cyc = i;
                applyStimulus(1'b1, 8'h22, 5'd1, 1'b0, 8'h00);
                break;
            end
            applyStimulus(1'b1, 8'h22, 5'd1, 1'b0, 8'h00);
        end
        checkOutput("b2b_accept_cycle", acc_cyc, done_cyc + 1);
        waitDone(50, bc, sc);
        checkOutput("b2b_done_pulses", done_pulses - base, 2);
        checkOutput("b2b_queue_empty", exp_done.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xfer_bus_driver.md
# xfer_bus_driver

Synthesizable transmit stage that drives the byte-serial bus sampled by the interface-side `sample_data_with_wait` collector. It accepts a transfer request (address plus byte length), fetches payload bytes from an internal FIFO, and places one byte per cycle on `bus_data`. It then raises `stop_cond` so the downstream sampler can end its wait and disable its sampling process. It sits between the transaction source and the bus interface.

## Interface
- `DEPTH`, 4: payload FIFO entries; a power of two, at least 2.
- `STOP_CYCLES`, 2: cycles `stop_cond` is held high; at least 1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: transfer request valid.
- `req_ready` out 1: request accepted when high with `req_valid`.
- `req_addr` in 8: transfer address.
- `req_len` in 5: payload byte count, 0..31.
- `byte_valid` in 1: payload byte valid.
- `byte_ready` out 1: high when the FIFO is not full.
- `byte_data` in 8: payload byte.
- `bus_data` out 8: driven address or data byte.
- `bus_valid` out 1: `bus_data` is meaningful this cycle.
- `bus_is_addr` out 1: `bus_data` carries the address.
- `stop_cond` out 1: stop condition, held for `STOP_CYCLES`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `done_count` out 5: bytes sent in the finished transfer; valid with `done`.

## Operation
- FSM states: IDLE, ADDR, DATA, STOP.
- IDLE:
  - `req_ready`=1.
  - A request handshake latches `req_addr` and `req_len` and goes to ADDR.
- ADDR:
  - Exactly one cycle, with `bus_data`=addr, `bus_valid`=1, `bus_is_addr`=1.
  - Next state is DATA if len>0, otherwise STOP.
- DATA:
  - Each cycle the FIFO is non-empty: pop one byte, drive it with `bus_valid`=1, and increment `sent` (5-bit).
  - FIFO empty: `bus_valid`=0 and `bus_data` holds its last value (a stall).
  - After the byte where `sent`+1==len, go to STOP.
- STOP:
  - `stop_cond`=1 and `bus_valid`=0 for `STOP_CYCLES` cycles, counted by a down-counter.
  - On the last STOP cycle, pulse `done` with `done_count`=`sent`, then go to IDLE.
- The FIFO accepts bytes in every state, so prefill before the request is allowed.
- A transfer consumes exactly len bytes. Surplus bytes stay queued for the next transfer.
- FIFO push and pop in the same cycle are both performed and the occupancy is unchanged. A push to a full FIFO is impossible because `byte_ready`=0.
- `req_len`=31 is legal. The `sent` counter never wraps because it stops at len.
- `req_valid` outside IDLE is ignored (`req_ready`=0) and is not queued.

## Timing
- Reset values while `rst_n`=0:
  - state IDLE, FIFO empty, `sent`=0.
  - `bus_data`=8'h00; `bus_valid`, `bus_is_addr`, `stop_cond`, `busy`, `done`=0; `done_count`=0.
  - `req_ready`=1; `byte_ready`=1.
- All bus outputs are registered and change one cycle after the causing event.
- A request accepted at edge N gives ADDR on the bus after N and the first data byte after N+1, provided the FIFO holds data.
- A transfer with len=L and no stalls occupies 1+L+`STOP_CYCLES` cycles from ADDR through the last STOP cycle.
- `req_ready` returns to 1 in the cycle after `done`, so back-to-back requests are accepted immediately.
- Reset asserted mid-transfer clears every output and the FIFO asynchronously. No `done` is produced and the partial transfer is discarded.
- The downstream sampler sees `stop_cond` rise no earlier than one cycle after the last data byte.

## Structure
- Package `xfer_pkg`:
  - `transfer_s`: `data[7:0]`, `addr[7:0]`, `count` int. This is the shared record type for the bus and the monitors.
  - The FSM state enum `xfer_state_e`.
  - Constants `XFER_LEN_W`=5 and `XFER_BYTE_W`=8.
- Sub-module `xfer_byte_fifo`:
  - Parameterized by `DEPTH`, with an occupancy counter and pointer wrap modulo `DEPTH`.
  - Ports: push/pop, full/empty, `rdata`.
- The top contains only the FSM, `sent`, the stop counter and the output registers.

## Test plan
- Prefill bytes AA, BB; request addr=10, len=2.
  - Bus shows 10 with `bus_is_addr`=1, then AA, BB.
  - `stop_cond` is high for 2 cycles.
  - `done` pulses with `done_count`=2; the sampler records data=BB, count=2.
- Request len=0, addr=3C.
  - ADDR cycle, then immediately STOP.
  - `done_count`=0, and the total is 3 busy cycles.
- Request len=3 with an empty FIFO; push one byte every 3 cycles.
  - `bus_valid` gaps of 2 cycles with `bus_data` held.
  - Exactly 3 data beats, then STOP.
- Fill the FIFO to `DEPTH`=4.
  - `byte_ready`=0 and an extra push is refused.
  - A len=2 transfer leaves 2 bytes, which the next len=2 transfer emits in order.
- Assert `rst_n` low during DATA of a len=5 transfer.
  - All outputs are 0 immediately; `req_ready`=1 after release.
  - No `done`; the FIFO is empty.
- Two back-to-back requests, len=1 and len=1.
  - The second is accepted in the cycle after the first `done`.
  - Two `done` pulses, each with count=1.
